// File: rtl/scan_mux_reg_pkg.sv
// Shared definitions for the scan_mux_reg block.
//   scan_mode_e   : encoding of the mode input (manual select / auto-scan)
//   DEFAULT_DWELL : dwell interval used by board top levels (1 s at 50 MHz)
//   DEFAULT_CNTW  : dwell counter width that holds DEFAULT_DWELL-1
package scan_mux_reg_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } scan_mode_e;

    localparam int DEFAULT_DWELL = 50000000;
    localparam int DEFAULT_CNTW  = 26;

endpackage

// File: rtl/scan_mux_reg_dwell_timer.sv
// Dwell interval timer for the auto-scan pointer.
//   Clock  : system clock
//   Resetn : asynchronous active-low reset
//   clr    : force count to 0 (takes priority over en)
//   en     : count this cycle
//   tick   : high for the enabled cycle in which the count sits at DWELL-1;
//            the count wraps to 0 on that same edge
module dwell_timer #(
    parameter int DWELL = 3,
    parameter int CNTW  = 2
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);

    logic [CNTW-1:0] cnt;

    assign tick = en && (cnt == LAST_CNT);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNTW'(1);
        end
    end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel, W-bit multiplexer with manual select and auto-scan.
//   Clock     : system clock, rising edge
//   Resetn    : asynchronous active-low reset
//   data_in   : packed channels, channel k at [k*W +: W]
//   sel       : manual channel select
//   mode      : 0 manual, 1 auto-scan
//   hold      : freeze pointer, dwell count and all outputs
//   out_data  : registered data of the selected channel
//   out_ch    : channel index currently driving out_data
//   ch_strobe : one-cycle pulse when out_ch changes
//   out_err   : high while the manual select is out of range
module scan_mux_reg
    import scan_mux_reg_pkg::*;
#(
    parameter int W     = 1,
    parameter int N     = 7,
    parameter int SELW  = 3,
    parameter int DWELL = DEFAULT_DWELL,
    parameter int CNTW  = DEFAULT_CNTW
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [N*W-1:0]  data_in,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            hold,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            ch_strobe,
    output logic            out_err
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    logic [SELW-1:0] ptr, ptr_nxt, ch_nxt;
    logic [W-1:0]    data_nxt;
    logic            err_nxt;
    logic            mode_q;
    logic            run, sel_ok, scan_entry, scanning, tick, tmr_clr;

    function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus,
                                          input logic [SELW-1:0] idx);
        pick = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) pick = bus[k*W +: W];
        end
    endfunction

    // mode_q only updates on non-hold edges, so a mode change made during
    // hold is seen as an edge on the first released cycle.
    assign run        = !hold;
    assign sel_ok     = (sel <= LAST_CH);
    assign scan_entry = run && (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
    assign scanning   = run && (mode == MODE_SCAN) && (mode_q == MODE_SCAN);
    assign tmr_clr    = run && ((mode == MODE_MANUAL) || scan_entry);

    dwell_timer #(
        .DWELL (DWELL),
        .CNTW  (CNTW)
    ) u_dwell_timer (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (tmr_clr),
        .en     (scanning),
        .tick   (tick)
    );

    always_comb begin
        ptr_nxt  = ptr;
        ch_nxt   = out_ch;
        data_nxt = out_data;
        err_nxt  = out_err;
        if (run) begin
            if (mode == MODE_SCAN) begin
                if (scan_entry) begin
                    ptr_nxt = sel_ok ? sel : '0;
                end else if (tick) begin
                    ptr_nxt = (ptr == LAST_CH) ? '0 : ptr + SELW'(1);
                end
                // Output follows the updated pointer so the advance lands
                // exactly DWELL edges after scan entry.
                ch_nxt   = ptr_nxt;
                data_nxt = pick(data_in, ptr_nxt);
                err_nxt  = 1'b0;
            end else if (sel_ok) begin
                ch_nxt   = sel;
                data_nxt = pick(data_in, sel);
                err_nxt  = 1'b0;
            end else begin
                data_nxt = '0;
                err_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ptr       <= '0;
            mode_q    <= MODE_MANUAL;
            out_ch    <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
            ch_strobe <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            out_ch    <= ch_nxt;
            out_data  <= data_nxt;
            out_err   <= err_nxt;
            ch_strobe <= (ch_nxt != out_ch);
            if (run) mode_q <= mode;
        end
    end

endmodule

// File: tb/tb_scan_mux_reg.sv
module tb_scan_mux_reg;

    localparam int W     = 4;
    localparam int N     = 7;
    localparam int SELW  = 3;
    localparam int DWELL = 3;
    localparam int CNTW  = 2;

    logic            Clock = 1'b0;
    logic            Resetn;
    logic [N*W-1:0]  data_in;
    logic [SELW-1:0] sel;
    logic            mode;
    logic            hold;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            ch_strobe;
    logic            out_err;

    int total = 0;
    int bad   = 0;

    scan_mux_reg #(
        .W(W), .N(N), .SELW(SELW), .DWELL(DWELL), .CNTW(CNTW)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .data_in   (data_in),
        .sel       (sel),
        .mode      (mode),
        .hold      (hold),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .ch_strobe (ch_strobe),
        .out_err   (out_err)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ch, input int dat,
                           input int stb, input int err);
        chk({tag, ".ch"},     16'(out_ch),    16'(ch));
        chk({tag, ".data"},   16'(out_data),  16'(dat));
        chk({tag, ".strobe"}, 16'(ch_strobe), 16'(stb));
        chk({tag, ".err"},    16'(out_err),   16'(err));
    endtask

    task automatic cyc();
        @(negedge Clock);
    endtask

    initial begin
        int scan_exp[10] = '{5, 5, 5, 6, 6, 6, 0, 0, 0, 1};
        int prev;

        Resetn = 1'b0;
        mode   = 1'b0;
        hold   = 1'b0;
        sel    = '0;
        for (int k = 0; k < N; k++) data_in[k*W +: W] = W'(k + 1);

        cyc();
        chk_out("reset", 0, 0, 0, 0);
        Resetn = 1'b1;

        // manual select of channel 5
        sel = 3'd5;
        cyc();
        chk_out("man_sel5", 5, 6, 1, 0);
        cyc();
        chk_out("man_sel5_hold", 5, 6, 0, 0);

        // out-of-range select
        sel = 3'd7;
        cyc();
        chk_out("man_bad", 5, 0, 0, 1);

        // asynchronous reset mid-cycle with nonzero outputs
        sel = 3'd5;
        cyc();
        chk_out("man_back5", 5, 6, 0, 0);
        #2 Resetn = 1'b0;
        #1 chk_out("async_rst", 0, 0, 0, 0);
        cyc();
        Resetn = 1'b1;
        cyc();
        chk_out("post_rst", 5, 6, 1, 0);

        // scan from channel 5 with wrap
        mode = 1'b1;
        prev = 5;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_out($sformatf("scan%0d", i), scan_exp[i], scan_exp[i] + 1,
                    (scan_exp[i] != prev) ? 1 : 0, 0);
            prev = scan_exp[i];
        end

        // hold after one dwell cycle on channel 1
        cyc();
        chk_out("pre_hold", 1, 2, 0, 0);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_out($sformatf("hold%0d", i), 1, 2, 0, 0);
        end
        hold = 1'b0;
        cyc();
        chk_out("rel1", 1, 2, 0, 0);
        cyc();
        chk_out("rel2", 2, 3, 1, 0);

        // live data change mid-dwell on channel 2
        data_in[2*W +: W] = 4'd9;
        cyc();
        chk_out("live", 2, 9, 0, 0);
        cyc();
        chk_out("live2", 2, 9, 0, 0);

        // leave scan on the expiry edge
        mode = 1'b0;
        sel  = 3'd3;
        cyc();
        chk_out("collide", 3, 4, 1, 0);

        // re-enter scan from 4; invalid sel during scan is ignored
        mode = 1'b1;
        sel  = 3'd4;
        cyc();
        chk_out("entry4", 4, 5, 1, 0);
        sel = 3'd7;
        cyc();
        chk_out("scan_badsel1", 4, 5, 0, 0);
        cyc();
        chk_out("scan_badsel2", 4, 5, 0, 0);
        cyc();
        chk_out("scan_adv5", 5, 6, 1, 0);

        // mode change during hold is deferred; invalid sel enters at 0
        mode = 1'b0;
        cyc();
        chk_out("man_bad2", 5, 0, 0, 1);
        hold = 1'b1;
        mode = 1'b1;
        cyc();
        chk_out("hold_mode", 5, 0, 0, 1);
        hold = 1'b0;
        cyc();
        chk_out("entry0", 0, 1, 1, 0);
        cyc();
        chk_out("entry0_b", 0, 1, 0, 0);
        cyc();
        chk_out("entry0_c", 0, 1, 0, 0);
        cyc();
        chk_out("adv1", 1, 2, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
